systolic_out_deskew: RTL and testbench
======================================

# systolic_out_deskew

Output-side alignment stage for the systolic array: removes the per-column skew that the input-side diagonal delay introduces, so each result row leaves as one aligned vector. Packs aligned rows into a small output FIFO with valid/ready handshake toward the write-back buffer. Tracks a per-job row count and flags the last row. The array cannot be stalled, so loss of a row is reported, never back-pressured.

## Interface
- ACC_WIDTH, 32, width of one column result
- ARRAY, 16, number of columns (lanes)
- FIFO_DEPTH, 4, aligned-row entries (power of 2, ≥2)
- ROW_CNT_W, 16, width of row counter
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  ARRAY  per-lane valid; lane n of a row arrives exactly n cycles after lane 0
- in_data  in  ARRAY*ACC_WIDTH  lane n at [n*ACC_WIDTH +: ACC_WIDTH]
- start  in  1  single-cycle job start; honoured only in IDLE
- num_rows  in  ROW_CNT_W  rows in job, sampled with start
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  ARRAY*ACC_WIDTH  aligned row, same lane packing
- out_last  out  1  head is final row of job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion
- overflow  out  1  sticky: aligned row arrived with FIFO full
- skew_err  out  1  sticky: aligned lane valids not all equal

## Operation
- Deskew: lane n passes through ARRAY-1-n register stages (lane ARRAY-1: zero stages); data and valid delayed together. Delay valid bits cleared by reset; data registers are not reset.
- Alignment register captures all lanes plus valids each cycle.
- Aligned row event: any aligned valid bit set. All set → good row; mixed → skew_err set, row dropped, not counted.
- States: IDLE, RUN, DRAIN.
- IDLE: good rows dropped silently. start with num_rows=0 → done pulses next cycle, stay IDLE. start with num_rows>0 → latch num_rows, clear pushed count, go RUN.
- RUN: good row pushed to FIFO if not full, or if full and a pop occurs in the same cycle; else overflow set, row dropped, not counted. Each push increments pushed count; the push with pushed == num_rows-1 carries last=1 and moves to DRAIN.
- DRAIN: good rows dropped silently. When FIFO is empty and no pop is in progress: done pulses, go IDLE.
- start while busy ignored. overflow and skew_err cleared only by reset or an accepted start.
- Pop when out_valid && out_ready. out_last is the stored tag of the head.
- Reset mid-job: state IDLE, FIFO empty, deskew valids cleared, counters zero, sticky flags zero; in-flight rows lost.

## Timing
- Reset values: out_valid 0, out_last 0, busy 0, done 0, overflow 0, skew_err 0. out_data is don't-care while out_valid is 0.
- Lane 0 of a row at cycle t0 → aligned register holds the row in cycle t0+ARRAY → FIFO write at end of that cycle → out_valid in cycle t0+ARRAY+1 if FIFO was empty. Fixed latency ARRAY+1.
- Throughput: one row per cycle sustained with out_ready held high.
- Full FIFO with simultaneous pop and push: both occur; occupancy unchanged, no overflow.
- done pulses the cycle after the final pop is accepted. busy drops in the same cycle as done.
- start accepted in cycle t: busy=1 from t+1.

## Structure
- Shared package holds: state encoding (IDLE/RUN/DRAIN as localparams), the lane-slice helper macro/function, and default ACC_WIDTH/ARRAY constants shared with the input-side skew stage.
- One sub-module: sync_fifo (parameterised width/depth, full/empty, simultaneous read/write), width ACC_WIDTH*ARRAY+1 to carry the last tag.
- Deskew chains stay inline via generate, built from the existing register_sync cell.

## Test plan
- ARRAY=4, num_rows=3: three rows fed skewed, lane n value = 16*row+n, out_ready=1. Expect out_valid at cycles t0+5, +6, +7 with data {3,2,1,0}, {19,18,17,16}, {35,34,33,32}; out_last only on the third row; done one cycle after the third pop.
- FIFO_DEPTH=4, out_ready=0, num_rows=6, 6 consecutive rows. Expect 4 stored, overflow=1 on row 5, busy stays 1. Raise out_ready: 4 pops, last tag never seen, no done.
- Full FIFO, out_ready=1 on the cycle row 5 aligns. Expect no overflow and 5 rows delivered in order.
- Lane 2 valid suppressed for one row. Expect skew_err=1, that row absent, remaining rows delivered, pushed count excludes the bad row.
- start with num_rows=0. Expect done pulse at t+1, busy never 1. Rows arriving in IDLE produce no out_valid.
- reset asserted mid-job with 2 rows in FIFO and 1 in the deskew chain. Expect all outputs at reset values next cycle, no stale row emitted afterwards.

Source files
------------

// File: rtl/systolic_out_deskew_pkg.sv
// Shared definitions for the systolic array output stage: FSM encoding, default geometry
// and the lane-slice offset helper, also used by the input-side skew stage.
package systolic_out_deskew_pkg;

  localparam int ACC_WIDTH_DEF = 32;
  localparam int ARRAY_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bit offset of lane n inside a packed row.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_out_deskew_sync_fifo.sv
// Single-clock FIFO; 1-cycle write-to-read latency; full/empty are exposed and the caller gates writes.
// A write while full is legal only when a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;

endmodule

// File: rtl/systolic_out_deskew.sv
// Deskews per-column results into aligned rows and queues them for write-back; latency ARRAY+1.
// The array cannot stall: rows that find the FIFO full are dropped and flagged via overflow.
module systolic_out_deskew
  import systolic_out_deskew_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int ARRAY      = ARRAY_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ARRAY-1:0]             in_valid,
  input  logic [ARRAY*ACC_WIDTH-1:0]   in_data,
  input  logic                         start,
  input  logic [ROW_CNT_W-1:0]         num_rows,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ARRAY*ACC_WIDTH-1:0]   out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic                         skew_err
);

  localparam int RW = ARRAY * ACC_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ARRAY-1:0] dsk_vld;
  logic [RW-1:0]    dsk_dat;

  // Lane n arrives n cycles after lane 0, so it is held ARRAY-1-n cycles to line up.
  for (genvar n = 0; n < ARRAY; n++) begin : g_lane
    localparam int STG = ARRAY - 1 - n;
    if (STG == 0) begin : g_pass
      assign dsk_vld[n] = in_valid[n];
      assign dsk_dat[lane_lsb(n, ACC_WIDTH) +: ACC_WIDTH] = in_data[lane_lsb(n, ACC_WIDTH) +: ACC_WIDTH];
    end else begin : g_chain
      logic [ACC_WIDTH-1:0] d_q [STG];
      logic [STG-1:0]       v_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= '0;
        end else begin
          v_q[0] <= in_valid[n];
          for (int i = 1; i < STG; i++) v_q[i] <= v_q[i-1];
        end
      end
      always_ff @(posedge clk) begin
        d_q[0] <= in_data[lane_lsb(n, ACC_WIDTH) +: ACC_WIDTH];
        for (int i = 1; i < STG; i++) d_q[i] <= d_q[i-1];
      end
      assign dsk_vld[n] = v_q[STG-1];
      assign dsk_dat[lane_lsb(n, ACC_WIDTH) +: ACC_WIDTH] = d_q[STG-1];
    end
  end

  logic [ARRAY-1:0] al_vld_q;
  logic [RW-1:0]    al_dat_q;

  always_ff @(posedge clk) begin
    if (reset) al_vld_q <= '0;
    else       al_vld_q <= dsk_vld;
  end

  always_ff @(posedge clk) begin
    al_dat_q <= dsk_dat;
  end

  logic good_row, bad_row;
  assign good_row = &al_vld_q;
  assign bad_row  = (|al_vld_q) && !good_row;

  state_t               state_q, state_d;
  logic [ROW_CNT_W-1:0] rows_q, pushed_q;
  logic                 done_q, overflow_q, skew_err_q;
  logic                 done_d, start_acc, push, last_push, pop, ovf_evt;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_cnt;
  logic [RW:0]          fifo_rd;

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    push      = 1'b0;
    last_push = 1'b0;
    ovf_evt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (num_rows == '0) done_d  = 1'b1;
          else                state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (good_row) begin
          if (!fifo_full || pop) begin
            push      = 1'b1;
            last_push = (pushed_q == rows_q - ROW_CNT_W'(1));
            if (last_push) state_d = ST_DRAIN;
          end else begin
            ovf_evt = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Finish on the cycle the final pop is accepted so done and !busy coincide next cycle.
        if (fifo_empty || (fifo_cnt == CW'(1) && pop)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rows_q     <= '0;
      pushed_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        rows_q     <= num_rows;
        pushed_q   <= '0;
        overflow_q <= 1'b0;
        skew_err_q <= 1'b0;
      end else begin
        if (push)    pushed_q   <= pushed_q + ROW_CNT_W'(1);
        if (ovf_evt) overflow_q <= 1'b1;
        if (bad_row) skew_err_q <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (RW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({last_push, al_dat_q}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd[RW-1:0];
  assign out_last  = out_valid && fifo_rd[RW];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign skew_err  = skew_err_q;

endmodule

// File: tb/tb_systolic_out_deskew.sv
// Directed bench for systolic_out_deskew with ARRAY=4: latency, overflow, simultaneous push/pop,
// skew detection, empty jobs and mid-job reset.
module tb_systolic_out_deskew;

  localparam int AW  = 32;
  localparam int NA  = 4;
  localparam int RCW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NA-1:0]   in_valid;
  logic [NA*AW-1:0] in_data;
  logic            start;
  logic [RCW-1:0]  num_rows;
  logic            out_valid;
  logic            out_ready;
  logic [NA*AW-1:0] out_data;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            overflow;
  logic            skew_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int       s_t0[$];
  int       s_base[$];
  logic [3:0] s_mask[$];

  always #5 clk = ~clk;

  systolic_out_deskew #(
    .ACC_WIDTH  (AW),
    .ARRAY      (NA),
    .FIFO_DEPTH (4),
    .ROW_CNT_W  (RCW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .start     (start),
    .num_rows  (num_rows),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  // Expected aligned row: lane n holds base+n.
  function automatic logic [NA*AW-1:0] row_word(input int base);
    logic [NA*AW-1:0] w;
    for (int n = 0; n < NA; n++) w[n*AW +: AW] = AW'(base + n);
    return w;
  endfunction

  task automatic sched_row(input int t0, input int base, input logic [3:0] mask);
    s_t0.push_back(t0);
    s_base.push_back(base);
    s_mask.push_back(mask);
  endtask

  // Advance one cycle, then drive the skewed lanes belonging to the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    in_valid = '0;
    in_data  = '0;
    foreach (s_t0[i]) begin
      int d;
      d = cyc - s_t0[i];
      if (d >= 0 && d < NA && s_mask[i][d]) begin
        in_valid[d] = 1'b1;
        in_data[d*AW +: AW] = AW'(s_base[i] + d);
      end
    end
  endtask

  task automatic do_reset();
    s_t0.delete();
    s_base.delete();
    s_mask.delete();
    reset     = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    out_ready = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_last, busy, done, overflow, skew_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=000000", {out_valid, out_last, busy, done, overflow, skew_err});
    end
  endtask

  task automatic test_latency();
    int c0, t0, k;
    do_reset();
    step();
    start = 1'b1; num_rows = 16'd3; out_ready = 1'b1;
    c0 = cyc; t0 = c0 + 2;
    for (int r = 0; r < 3; r++) sched_row(t0 + r, 16 * r, 4'hf);
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy_after_start got=%b exp=1", busy); end
    while (cyc < t0) step();
    for (k = 0; k <= 10; k++) begin
      logic ev;
      ev = (k >= 5 && k <= 7);
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("FAIL lat_valid k=%0d got=%b exp=%b", k, out_valid, ev); end
      if (ev) begin
        n_checks++;
        if (out_data !== row_word(16 * (k - 5))) begin
          n_fail++; $display("FAIL lat_data k=%0d got=%h exp=%h", k, out_data, row_word(16 * (k - 5)));
        end
        n_checks++;
        if (out_last !== (k == 7)) begin n_fail++; $display("FAIL lat_last k=%0d got=%b exp=%b", k, out_last, k == 7); end
      end
      n_checks++;
      if (done !== (k == 8)) begin n_fail++; $display("FAIL lat_done k=%0d got=%b exp=%b", k, done, k == 8); end
      n_checks++;
      if (busy !== (k < 8)) begin n_fail++; $display("FAIL lat_busy k=%0d got=%b exp=%b", k, busy, k < 8); end
      step();
    end
  endtask

  task automatic test_overflow();
    int t0, k;
    do_reset();
    step();
    start = 1'b1; num_rows = 16'd6; out_ready = 1'b0;
    t0 = cyc + 2;
    for (int r = 0; r < 6; r++) sched_row(t0 + r, 16 * r, 4'hf);
    step();
    start = 1'b0;
    while (cyc < t0) step();
    for (k = 0; k <= 12; k++) begin
      n_checks++;
      if (overflow !== (k >= 9)) begin n_fail++; $display("FAIL ovf_flag k=%0d got=%b exp=%b", k, overflow, k >= 9); end
      n_checks++;
      if (out_valid !== (k >= 5)) begin n_fail++; $display("FAIL ovf_valid k=%0d got=%b exp=%b", k, out_valid, k >= 5); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy k=%0d got=%b exp=1", k, busy); end
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== row_word(16 * i) || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_pop i=%0d got=%b/%h/%b exp=1/%h/0", i, out_valid, out_data, out_last, row_word(16 * i));
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out_valid, done, busy} !== 3'b001) begin
        n_fail++; $display("FAIL ovf_after i=%0d got=%b exp=001", i, {out_valid, done, busy});
      end
      step();
    end
  endtask

  task automatic test_full_push_pop();
    int t0, k;
    do_reset();
    step();
    start = 1'b1; num_rows = 16'd5; out_ready = 1'b0;
    t0 = cyc + 2;
    for (int r = 0; r < 5; r++) sched_row(t0 + r, 16 * r + 100, 4'hf);
    step();
    start = 1'b0;
    while (cyc < t0) step();
    for (k = 0; k <= 14; k++) begin
      logic ev;
      out_ready = (k >= 8);
      ev = (k >= 5 && k <= 12);
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("FAIL full_valid k=%0d got=%b exp=%b", k, out_valid, ev); end
      if (k >= 8 && k <= 12) begin
        n_checks++;
        if (out_data !== row_word(16 * (k - 8) + 100) || out_last !== (k == 12)) begin
          n_fail++;
          $display("FAIL full_data k=%0d got=%h/%b exp=%h/%b", k, out_data, out_last, row_word(16 * (k - 8) + 100), k == 12);
        end
      end
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow k=%0d got=%b exp=0", k, overflow); end
      n_checks++;
      if (done !== (k == 13)) begin n_fail++; $display("FAIL full_done k=%0d got=%b exp=%b", k, done, k == 13); end
      step();
    end
  endtask

  task automatic test_skew();
    int t0, k, rr;
    do_reset();
    step();
    start = 1'b1; num_rows = 16'd3; out_ready = 1'b1;
    t0 = cyc + 2;
    sched_row(t0,     0,  4'hf);
    sched_row(t0 + 1, 16, 4'b1011);
    sched_row(t0 + 2, 32, 4'hf);
    sched_row(t0 + 3, 48, 4'hf);
    step();
    start = 1'b0;
    while (cyc < t0) step();
    for (k = 0; k <= 11; k++) begin
      logic ev;
      ev = (k == 5 || k == 7 || k == 8);
      rr = (k == 5) ? 0 : (k == 7) ? 2 : 3;
      n_checks++;
      if (out_valid !== ev) begin n_fail++; $display("FAIL skew_valid k=%0d got=%b exp=%b", k, out_valid, ev); end
      if (ev) begin
        n_checks++;
        if (out_data !== row_word(16 * rr) || out_last !== (k == 8)) begin
          n_fail++; $display("FAIL skew_data k=%0d got=%h/%b exp=%h/%b", k, out_data, out_last, row_word(16 * rr), k == 8);
        end
      end
      n_checks++;
      if (skew_err !== (k >= 6)) begin n_fail++; $display("FAIL skew_flag k=%0d got=%b exp=%b", k, skew_err, k >= 6); end
      n_checks++;
      if (done !== (k == 9)) begin n_fail++; $display("FAIL skew_done k=%0d got=%b exp=%b", k, done, k == 9); end
      step();
    end
  endtask

  task automatic test_zero_rows();
    int c0;
    do_reset();
    step();
    start = 1'b1; num_rows = 16'd0; out_ready = 1'b1;
    c0 = cyc;
    sched_row(c0 + 1, 200, 4'hf);
    sched_row(c0 + 2, 216, 4'hf);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_start got=%b exp=0", busy); end
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if ({done, busy, out_valid} !== {k == 1, 2'b00}) begin
        n_fail++; $display("FAIL zero_state k=%0d got=%b exp=%b", k, {done, busy, out_valid}, {k == 1, 2'b00});
      end
      step();
    end
  endtask

  task automatic test_reset_mid_job();
    int t0;
    do_reset();
    step();
    start = 1'b1; num_rows = 16'd5; out_ready = 1'b0;
    t0 = cyc + 2;
    for (int r = 0; r < 4; r++) sched_row(t0 + r, 16 * r + 300, 4'hf);
    step();
    start = 1'b0;
    while (cyc < t0 + 6) step();
    n_checks++;
    if ({out_valid, busy} !== 2'b11) begin n_fail++; $display("FAIL midrst_pre got=%b exp=11", {out_valid, busy}); end
    s_t0.delete(); s_base.delete(); s_mask.delete();
    in_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if ({out_valid, out_last, busy, done, overflow, skew_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs got=%b exp=000000", {out_valid, out_last, busy, done, overflow, skew_err});
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({out_valid, busy, done, skew_err} !== 4'b0) begin
        n_fail++; $display("FAIL midrst_stale k=%0d got=%b exp=0000", k, {out_valid, busy, done, skew_err});
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    out_ready = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    test_reset();
    test_latency();
    test_overflow();
    test_full_push_pop();
    test_skew();
    test_zero_rows();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
